sized_fifo_unpacker: RTL and testbench

- Consumer-side companion to the team's sized FIFOs. It drains wide words from a FIFO dequeue interface (D_OUT/EMPTY_N/DEQ style) and re-enqueues them as narrow beats into a downstream FIFO enqueue interface (D_IN/ENQ/FULL_N style).
- Used as a gearbox on wide-to-narrow datapaths.
- The last beat of a word and the dequeue of the next word happen in the same cycle, giving full throughput with no bubbles.

---
 rtl/sized_fifo_unpacker_if.sv | 24 ++
 rtl/sized_fifo_unpacker.sv | 101 ++++++++++
 tb/tb_sized_fifo_unpacker.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sized_fifo_unpacker_if.sv
// Handshake bundle for the wide-to-narrow unpacker: upstream FIFO dequeue side
// and downstream FIFO enqueue side.
interface sized_fifo_unpacker_if #(
   parameter int in_width  = 32,
   parameter int out_width = 8
);
   logic [in_width-1:0]  IN_D;
   logic                 IN_EMPTY_N;
   logic                 IN_DEQ;
   logic [out_width-1:0] OUT_D;
   logic                 OUT_LAST;
   logic                 OUT_ENQ;
   logic                 OUT_FULL_N;

   modport master (
      output IN_D, IN_EMPTY_N, OUT_FULL_N,
      input  IN_DEQ, OUT_D, OUT_LAST, OUT_ENQ
   );

   modport slave (
      input  IN_D, IN_EMPTY_N, OUT_FULL_N,
      output IN_DEQ, OUT_D, OUT_LAST, OUT_ENQ
   );
endinterface

// File: rtl/sized_fifo_unpacker.sv
// Gearbox that drains wide FIFO words and re-enqueues them as narrow beats,
// LSB slice first, reloading the next word on the last beat with no bubble.
//
// state | meaning
// EMPTY | no word held; outputs gated off, dequeue whenever upstream has data
// HOLD  | word held in hold_q; beat_q selects the slice being offered
module sized_fifo_unpacker #(
   parameter int p1in_width  = 32,
   parameter int p2ratio     = 4,
   parameter int p3cnt_width = 2
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    CLR,
   sized_fifo_unpacker_if.slave    bus
);
   localparam int out_width = p1in_width / p2ratio;

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   localparam logic [p3cnt_width-1:0] beat_last = p3cnt_width'(p2ratio - 1);

   if (p2ratio < 2) begin : g_bad_ratio
      $fatal(1, "sized_fifo_unpacker: p2ratio must be >= 2");
   end
   if ((p1in_width % p2ratio) != 0) begin : g_bad_width
      $fatal(1, "sized_fifo_unpacker: p1in_width must be a multiple of p2ratio");
   end
   if ((2 ** p3cnt_width) < p2ratio) begin : g_bad_cnt
      $fatal(1, "sized_fifo_unpacker: p3cnt_width too narrow for p2ratio");
   end

   logic [p1in_width-1:0]  hold_q, hold_d;
   logic [0:0]             valid_q, valid_d;
   logic [p3cnt_width-1:0] beat_q, beat_d;

   logic                   out_enq;
   logic                   out_last;
   logic                   in_deq;
   logic                   take;
   logic [out_width-1:0]   out_d;

   // Reset also masks the strobes so no word is popped or beat pushed while
   // the block is being reset and would discard it.
   always_comb begin
      out_last = (valid_q == ST_HOLD) && (beat_q == beat_last);
      out_enq  = (valid_q == ST_HOLD) && bus.OUT_FULL_N && !CLR && RST_N;
      take     = out_enq && out_last;
      in_deq   = bus.IN_EMPTY_N && !CLR && RST_N && ((valid_q == ST_EMPTY) || take);
      out_d    = '0;
      if (valid_q == ST_HOLD) begin
         out_d = hold_q[int'(beat_q) * out_width +: out_width];
      end
   end

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      beat_d  = beat_q;
      if (CLR) begin
         valid_d = ST_EMPTY;
         beat_d  = '0;
      end else if (in_deq) begin
         hold_d  = bus.IN_D;
         valid_d = ST_HOLD;
         beat_d  = '0;
      end else if (take) begin
         valid_d = ST_EMPTY;
         beat_d  = '0;
      end else if (out_enq && !out_last) begin
         beat_d  = beat_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         valid_q <= ST_EMPTY;
         beat_q  <= '0;
      end else begin
         valid_q <= valid_d;
         beat_q  <= beat_d;
      end
   end

   // Data holding register is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      hold_q <= hold_d;
   end

   assign bus.IN_DEQ   = in_deq;
   assign bus.OUT_ENQ  = out_enq;
   assign bus.OUT_LAST = out_last;
   assign bus.OUT_D    = out_d;

   always_ff @(posedge CLK) begin
      if (RST_N) begin
         assert (!(in_deq && !bus.IN_EMPTY_N)) else $warning("Dequeuing from empty");
      end
   end
endmodule

// File: tb/tb_sized_fifo_unpacker.sv
// Directed bench for sized_fifo_unpacker with default parameters (32-bit words,
// four 8-bit beats); upstream and downstream FIFOs are emulated by hand.
module tb_sized_fifo_unpacker;
   logic clk;
   logic rst_n;
   logic clr;
   int   errors;
   int   checks;

   sized_fifo_unpacker_if #(.in_width(32), .out_width(8)) bus ();

   sized_fifo_unpacker #(
      .p1in_width (32),
      .p2ratio    (4),
      .p3cnt_width(2)
   ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .CLR  (clr),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs are set at posedge+1; outputs are compared at posedge+2, then the
   // next rising edge is taken.
   task automatic cycle(input string tag, input logic e_deq, input logic e_enq,
                        input logic e_last, input logic [7:0] e_d);
      #1;
      chk({tag, ".deq"},  {31'd0, bus.IN_DEQ},   {31'd0, e_deq});
      chk({tag, ".enq"},  {31'd0, bus.OUT_ENQ},  {31'd0, e_enq});
      chk({tag, ".last"}, {31'd0, bus.OUT_LAST}, {31'd0, e_last});
      chk({tag, ".d"},    {24'd0, bus.OUT_D},    {24'd0, e_d});
      @(posedge clk);
      #1;
   endtask

   initial begin
      errors         = 0;
      checks         = 0;
      rst_n          = 1'b0;
      clr            = 1'b0;
      bus.IN_D       = 32'h0;
      bus.IN_EMPTY_N = 1'b0;
      bus.OUT_FULL_N = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      cycle("rst", 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      cycle("idle", 1'b0, 1'b0, 1'b0, 8'h00);

      // single word
      bus.IN_D = 32'hDDCCBBAA; bus.IN_EMPTY_N = 1'b1;
      cycle("sw.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_EMPTY_N = 1'b0;
      cycle("sw.b0", 1'b0, 1'b1, 1'b0, 8'hAA);
      cycle("sw.b1", 1'b0, 1'b1, 1'b0, 8'hBB);
      cycle("sw.b2", 1'b0, 1'b1, 1'b0, 8'hCC);
      cycle("sw.b3", 1'b0, 1'b1, 1'b1, 8'hDD);
      cycle("sw.done", 1'b0, 1'b0, 1'b0, 8'h00);

      // back-to-back words, reload on the beat carrying 03
      bus.IN_D = 32'h03020100; bus.IN_EMPTY_N = 1'b1;
      cycle("bb.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_D = 32'h07060504;
      cycle("bb.b0", 1'b0, 1'b1, 1'b0, 8'h00);
      cycle("bb.b1", 1'b0, 1'b1, 1'b0, 8'h01);
      cycle("bb.b2", 1'b0, 1'b1, 1'b0, 8'h02);
      cycle("bb.b3", 1'b1, 1'b1, 1'b1, 8'h03);
      bus.IN_EMPTY_N = 1'b0;
      cycle("bb.b4", 1'b0, 1'b1, 1'b0, 8'h04);
      cycle("bb.b5", 1'b0, 1'b1, 1'b0, 8'h05);
      cycle("bb.b6", 1'b0, 1'b1, 1'b0, 8'h06);
      cycle("bb.b7", 1'b0, 1'b1, 1'b1, 8'h07);
      cycle("bb.done", 1'b0, 1'b0, 1'b0, 8'h00);

      // backpressure at beat 1
      bus.IN_D = 32'h44332211; bus.IN_EMPTY_N = 1'b1;
      cycle("bp.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_EMPTY_N = 1'b0;
      cycle("bp.b0", 1'b0, 1'b1, 1'b0, 8'h11);
      bus.OUT_FULL_N = 1'b0;
      cycle("bp.stall0", 1'b0, 1'b0, 1'b0, 8'h22);
      cycle("bp.stall1", 1'b0, 1'b0, 1'b0, 8'h22);
      cycle("bp.stall2", 1'b0, 1'b0, 1'b0, 8'h22);
      bus.OUT_FULL_N = 1'b1;
      cycle("bp.b1", 1'b0, 1'b1, 1'b0, 8'h22);
      cycle("bp.b2", 1'b0, 1'b1, 1'b0, 8'h33);
      cycle("bp.b3", 1'b0, 1'b1, 1'b1, 8'h44);
      cycle("bp.done", 1'b0, 1'b0, 1'b0, 8'h00);

      // downstream full on the last beat with upstream ready
      bus.IN_D = 32'hA3A2A1A0; bus.IN_EMPTY_N = 1'b1;
      cycle("fl.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_D = 32'hB3B2B1B0;
      cycle("fl.a0", 1'b0, 1'b1, 1'b0, 8'hA0);
      cycle("fl.a1", 1'b0, 1'b1, 1'b0, 8'hA1);
      cycle("fl.a2", 1'b0, 1'b1, 1'b0, 8'hA2);
      bus.OUT_FULL_N = 1'b0;
      cycle("fl.stall0", 1'b0, 1'b0, 1'b1, 8'hA3);
      cycle("fl.stall1", 1'b0, 1'b0, 1'b1, 8'hA3);
      bus.OUT_FULL_N = 1'b1;
      cycle("fl.a3", 1'b1, 1'b1, 1'b1, 8'hA3);
      bus.IN_EMPTY_N = 1'b0;
      cycle("fl.b0", 1'b0, 1'b1, 1'b0, 8'hB0);
      cycle("fl.b1", 1'b0, 1'b1, 1'b0, 8'hB1);
      cycle("fl.b2", 1'b0, 1'b1, 1'b0, 8'hB2);
      cycle("fl.b3", 1'b0, 1'b1, 1'b1, 8'hB3);
      cycle("fl.done", 1'b0, 1'b0, 1'b0, 8'h00);

      // clear at beat 2; 0x88 must never appear
      bus.IN_D = 32'h88776655; bus.IN_EMPTY_N = 1'b1;
      cycle("cl.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_D = 32'hC3C2C1C0;
      cycle("cl.b0", 1'b0, 1'b1, 1'b0, 8'h55);
      cycle("cl.b1", 1'b0, 1'b1, 1'b0, 8'h66);
      clr = 1'b1;
      cycle("cl.clr", 1'b0, 1'b0, 1'b0, 8'h77);
      clr = 1'b0;
      cycle("cl.reload", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_EMPTY_N = 1'b0;
      cycle("cl.c0", 1'b0, 1'b1, 1'b0, 8'hC0);
      cycle("cl.c1", 1'b0, 1'b1, 1'b0, 8'hC1);
      cycle("cl.c2", 1'b0, 1'b1, 1'b0, 8'hC2);
      cycle("cl.c3", 1'b0, 1'b1, 1'b1, 8'hC3);
      cycle("cl.done", 1'b0, 1'b0, 1'b0, 8'h00);

      // reset while holding a word
      bus.IN_D = 32'hD3D2D1D0; bus.IN_EMPTY_N = 1'b1;
      cycle("rs.load", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_D = 32'hE3E2E1E0;
      cycle("rs.d0", 1'b0, 1'b1, 1'b0, 8'hD0);
      rst_n = 1'b0;
      cycle("rs.assert", 1'b0, 1'b0, 1'b0, 8'hD1);
      cycle("rs.held", 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b1;
      cycle("rs.reload", 1'b1, 1'b0, 1'b0, 8'h00);
      bus.IN_EMPTY_N = 1'b0;
      cycle("rs.e0", 1'b0, 1'b1, 1'b0, 8'hE0);
      cycle("rs.e1", 1'b0, 1'b1, 1'b0, 8'hE1);
      cycle("rs.e2", 1'b0, 1'b1, 1'b0, 8'hE2);
      cycle("rs.e3", 1'b0, 1'b1, 1'b1, 8'hE3);
      cycle("rs.done", 1'b0, 1'b0, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
